// File: rtl/pu_sequencer.sv
// Control sequencer for one PU neuron lane. It walks the chunks of each neuron,
// pipelines the PU multiply/add strobes, and streams one ReLU result per neuron.
module pu_sequencer #(
   parameter int unsigned NUM_CHUNKS  = 8,
   parameter int unsigned NUM_NEURONS = 30,
   parameter int unsigned WADDR_W     = 5,
   parameter int unsigned DADDR_W     = 10,
   localparam int unsigned CHUNK_W    = $clog2(NUM_CHUNKS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [DADDR_W-1:0] sample_addr_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               mem_read_o,
   output logic [WADDR_W-1:0] w_addr_o,
   output logic [DADDR_W-1:0] d_addr_o,
   output logic [CHUNK_W-1:0] chunk_sel_o,
   output logic               ld_mult_o,
   output logic               ld_add_o,
   output logic               acc_o,
   input  logic [7:0]         pu_out_i,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic [WADDR_W-1:0] result_idx_o,
   output logic [7:0]         result_data_o
);

   typedef enum logic [2:0] {IDLE, FIRST, RUN, DRAIN, OUT, FIN} state_e;

   state_e               state_q, state_d;
   logic [WADDR_W-1:0]   neuron_q, neuron_d;
   logic [CHUNK_W-1:0]   chunk_q, chunk_d;
   logic [DADDR_W-1:0]   d_addr_q, d_addr_d;
   logic [CHUNK_W-1:0]   chunk_sel_q, chunk_sel_d;
   logic [WADDR_W-1:0]   result_idx_q, result_idx_d;
   logic [7:0]           result_q;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 ld_mult_q, ld_mult_d;
   logic                 ld_add_q, ld_add_d;
   logic                 acc_q, acc_d;
   logic                 valid_q, valid_d;
   logic                 out_first_q, out_first_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus next value of every registered output, decoded from state_d.
   always_comb begin
      state_d      = state_q;
      neuron_d     = neuron_q;
      chunk_d      = chunk_q;
      d_addr_d     = d_addr_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      ld_mult_d    = 1'b0;
      ld_add_d     = 1'b0;
      acc_d        = 1'b0;
      valid_d      = 1'b0;
      chunk_sel_d  = '0;
      result_idx_d = result_idx_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               d_addr_d = sample_addr_i;
               neuron_d = '0;
               chunk_d  = '0;
               state_d  = FIRST;
            end
         end
         FIRST: begin
            chunk_d = CHUNK_W'(1);
            state_d = RUN;
         end
         RUN: begin
            if (chunk_q == CHUNK_W'(NUM_CHUNKS - 1)) begin
               state_d = DRAIN;
            end else begin
               chunk_d = chunk_q + CHUNK_W'(1);
            end
         end
         DRAIN: state_d = OUT;
         OUT: begin
            if (result_ready_i) begin
               if (neuron_q == WADDR_W'(NUM_NEURONS - 1)) begin
                  state_d = FIN;
               end else begin
                  neuron_d = neuron_q + WADDR_W'(1);
                  chunk_d  = '0;
                  state_d  = FIRST;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      case (state_d)
         FIRST: begin
            busy_d    = 1'b1;
            ld_mult_d = 1'b1;
         end
         RUN: begin
            busy_d      = 1'b1;
            ld_mult_d   = 1'b1;
            ld_add_d    = 1'b1;
            chunk_sel_d = chunk_d;
            // First add of a neuron overwrites the previous neuron's sum.
            acc_d       = (chunk_d != CHUNK_W'(1));
         end
         DRAIN: begin
            busy_d   = 1'b1;
            ld_add_d = 1'b1;
            acc_d    = 1'b1;
         end
         OUT: begin
            busy_d       = 1'b1;
            valid_d      = 1'b1;
            result_idx_d = neuron_d;
         end
         FIN:     done_d = 1'b1;
         default: ;
      endcase

      out_first_d = (state_d == OUT) && (state_q != OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neuron_q     <= '0;
         chunk_q      <= '0;
         d_addr_q     <= '0;
         chunk_sel_q  <= '0;
         result_idx_q <= '0;
         result_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ld_mult_q    <= 1'b0;
         ld_add_q     <= 1'b0;
         acc_q        <= 1'b0;
         valid_q      <= 1'b0;
         out_first_q  <= 1'b0;
      end else begin
         neuron_q     <= neuron_d;
         chunk_q      <= chunk_d;
         d_addr_q     <= d_addr_d;
         chunk_sel_q  <= chunk_sel_d;
         result_idx_q <= result_idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ld_mult_q    <= ld_mult_d;
         ld_add_q     <= ld_add_d;
         acc_q        <= acc_d;
         valid_q      <= valid_d;
         out_first_q  <= out_first_d;
         if (out_first_q) begin
            result_q <= pu_out_i;
         end
      end
   end

   // The final add lands on the OUT entry edge, so the first OUT cycle passes pu_out through.
   assign result_data_o  = out_first_q ? pu_out_i : result_q;
   assign busy_o         = busy_q;
   assign mem_read_o     = busy_q;
   assign done_o         = done_q;
   assign w_addr_o       = neuron_q;
   assign d_addr_o       = d_addr_q;
   assign chunk_sel_o    = chunk_sel_q;
   assign ld_mult_o      = ld_mult_q;
   assign ld_add_o       = ld_add_q;
   assign acc_o          = acc_q;
   assign result_valid_o = valid_q;
   assign result_idx_o   = result_idx_q;

endmodule

// File: tb/tb_pu_sequencer.sv
// Bench for pu_sequencer: behavioural PU plus weight/bias/data memories, with a
// scoreboard of expected per-neuron results and directed protocol checks.
module tb_pu_sequencer;
   localparam int unsigned NC = 8;
   localparam int unsigned NN = 30;
   localparam int unsigned WW = 5;
   localparam int unsigned DW = 10;
   localparam int unsigned CW = 3;

   typedef struct packed {
      logic [WW-1:0] idx;
      logic [7:0]    data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] sample_addr;
   logic          busy, done, mem_read;
   logic [WW-1:0] w_addr;
   logic [DW-1:0] d_addr;
   logic [CW-1:0] chunk_sel;
   logic          ld_mult, ld_add, acc;
   logic [7:0]    pu_out;
   logic          result_valid, result_ready;
   logic [WW-1:0] result_idx;
   logic [7:0]    result_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int t0 = 0;

   logic [NC*64-1:0]  wh_mem   [32];
   logic signed [7:0] bias_mem [32];
   logic [NC*64-1:0]  data_mem [1024];
   int                prod_q, accum_q;
   logic [63:0]       x_c, w_c;

   exp_t sb_q [$];
   exp_t e;
   logic hold_v = 1'b0;
   logic [WW-1:0] hold_idx;
   logic [7:0] hold_data;
   logic prev_done = 1'b0;

   pu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .sample_addr_i(sample_addr),
      .busy_o(busy), .done_o(done), .mem_read_o(mem_read), .w_addr_o(w_addr),
      .d_addr_o(d_addr), .chunk_sel_o(chunk_sel), .ld_mult_o(ld_mult),
      .ld_add_o(ld_add), .acc_o(acc), .pu_out_i(pu_out),
      .result_valid_o(result_valid), .result_ready_i(result_ready),
      .result_idx_o(result_idx), .result_data_o(result_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int dot64(input logic [63:0] a, input logic [63:0] b);
      int s = 0;
      for (int i = 0; i < 8; i++) begin
         s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
      end
      return s;
   endfunction

   function automatic logic [7:0] relu8(input int s);
      if (s < 0) return 8'd0;
      if (s > 127) return 8'd127;
      return 8'(s);
   endfunction

   function automatic logic [7:0] golden(input int n, input int row);
      int s = int'(bias_mem[n]);
      for (int c = 0; c < NC; c++) begin
         s += dot64(data_mem[row][c*64 +: 64], wh_mem[n][c*64 +: 64]);
      end
      return relu8(s);
   endfunction

   // Behavioural two-stage PU: product register then accumulator.
   assign x_c    = data_mem[d_addr][{chunk_sel, 6'b0} +: 64];
   assign w_c    = wh_mem[w_addr][{chunk_sel, 6'b0} +: 64];
   assign pu_out = relu8(accum_q + int'(bias_mem[w_addr]));

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q  <= 0;
         accum_q <= 0;
      end else begin
         if (ld_mult) prod_q <= dot64(x_c, w_c);
         if (ld_add)  accum_q <= acc ? accum_q + prod_q : prod_q;
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard pop, hold stability and per-cycle protocol invariants.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("mem_read_eq_busy", mem_read, busy);
         chk("acc_without_add", acc & ~ld_add, 0);
         chk("chunk_sel_idle", (chunk_sel != 0) & ~ld_mult, 0);
         chk("done_one_cycle", done & prev_done, 0);
         if (done) chk("busy_in_done", busy, 0);
         prev_done = done;
         if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (result_valid && result_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("result_idx", result_idx, e.idx);
               chk("result_data", result_data, e.data);
            end
         end
         if (result_valid && !result_ready) begin
            if (hold_v) begin
               chk("hold_idx", result_idx, hold_idx);
               chk("hold_data", result_data, hold_data);
            end
            hold_v    = 1'b1;
            hold_idx  = result_idx;
            hold_data = result_data;
         end else begin
            hold_v = 1'b0;
         end
      end else begin
         prev_done = 1'b0;
         hold_v    = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int mode, input int row);
      for (int n = 0; n < 32; n++) begin
         bias_mem[n] = (mode == 2) ? 8'($urandom_range(0, 8)) - 8'd4 : 8'd0;
         for (int b = 0; b < NC*8; b++) begin
            wh_mem[n][b*8 +: 8] = (mode == 0) ? 8'd1 : (mode == 1) ? 8'd0
                                  : 8'($urandom_range(0, 6)) - 8'd3;
         end
      end
      for (int b = 0; b < NC*8; b++) begin
         data_mem[row][b*8 +: 8] = (mode == 2) ? 8'($urandom_range(0, 4)) : 8'd1;
      end
   endtask

   task automatic push_pass(input int mode, input int row);
      exp_t x;
      for (int n = 0; n < NN; n++) begin
         x.idx  = WW'(n);
         x.data = (mode == 0) ? 8'd64 : (mode == 1) ? 8'd0 : golden(n, row);
         sb_q.push_back(x);
      end
   endtask

   task automatic run_start(input int row);
      sample_addr = DW'(row);
      start       = 1'b1;
      t0          = cyc;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int len);
      int d0 = done_cnt;
      for (int i = 0; i < 700 && done_cnt == d0; i++) tick();
      chk({tag, "_done_seen"}, done_cnt - d0, 1);
      chk({tag, "_pass_len"}, last_done_cyc - t0, len);
      chk({tag, "_sb_empty"}, sb_q.size(), 0);
      repeat (3) tick();
      chk({tag, "_single_done"}, done_cnt - d0, 1);
      chk({tag, "_idle_busy"}, busy, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_mem_read"}, mem_read, 0);
      chk({tag, "_w_addr"}, w_addr, 0);
      chk({tag, "_d_addr"}, d_addr, 0);
      chk({tag, "_chunk_sel"}, chunk_sel, 0);
      chk({tag, "_ld_mult"}, ld_mult, 0);
      chk({tag, "_ld_add"}, ld_add, 0);
      chk({tag, "_acc"}, acc, 0);
      chk({tag, "_valid"}, result_valid, 0);
      chk({tag, "_idx"}, result_idx, 0);
      chk({tag, "_data"}, result_data, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int d0;
      rst_n        = 1'b0;
      start        = 1'b0;
      sample_addr  = '0;
      result_ready = 1'b1;
      for (int r = 0; r < 1024; r++) data_mem[r] = '0;
      fill(1, 0);
      #3;
      chk_zero("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // All-ones pass: strobe timing of the first neuron, then full pass length.
      fill(0, 5);
      push_pass(0, 5);
      run_start(5);
      chk("c1_ld_mult", ld_mult, 1);
      chk("c1_chunk_sel", chunk_sel, 0);
      chk("c1_w_addr", w_addr, 0);
      chk("c1_d_addr", d_addr, 5);
      chk("c1_ld_add", ld_add, 0);
      chk("c1_busy", busy, 1);
      for (int k = 2; k <= 9; k++) begin
         tick();
         chk("add_strobe", ld_add, 1);
         chk("acc_seq", acc, (k != 2) ? 1 : 0);
         chk("mult_seq", ld_mult, (k <= 8) ? 1 : 0);
         chk("chunk_seq", chunk_sel, (k <= 8) ? k - 1 : 0);
      end
      tick();
      chk("c10_valid", result_valid, 1);
      chk("c10_idx", result_idx, 0);
      chk("c10_ld_mult", ld_mult, 0);
      chk("c10_ld_add", ld_add, 0);
      wait_done("ones", 301);

      // Back-pressure on neuron 3 for five cycles.
      fill(2, 77);
      push_pass(2, 77);
      run_start(77);
      for (int i = 0; i < 100 && w_addr != 3; i++) tick();
      chk("reach_n3", w_addr, 3);
      result_ready = 1'b0;
      for (int i = 0; i < 20 && !result_valid; i++) tick();
      for (int s = 0; s < 5; s++) begin
         chk("stall_valid", result_valid, 1);
         chk("stall_idx", result_idx, 3);
         chk("stall_data", result_data, golden(3, 77));
         chk("stall_ld_mult", ld_mult, 0);
         chk("stall_ld_add", ld_add, 0);
         tick();
      end
      result_ready = 1'b1;
      wait_done("stall", 306);

      // Start pulsed mid-pass is ignored.
      fill(2, 300);
      push_pass(2, 300);
      run_start(300);
      repeat (49) tick();
      sample_addr = DW'(123);
      start       = 1'b1;
      tick();
      start       = 1'b0;
      chk("busy_start_w_addr", w_addr, 5);
      chk("busy_start_d_addr", d_addr, 300);
      chk("busy_start_chunk", chunk_sel, 0);
      chk("busy_start_ld_mult", ld_mult, 1);
      wait_done("busystart", 301);

      // Reset abort during neuron 12, then a fresh pass.
      fill(2, 9);
      push_pass(2, 9);
      run_start(9);
      for (int i = 0; i < 200 && w_addr != 12; i++) tick();
      chk("reach_n12", w_addr, 12);
      repeat (3) tick();
      chk("n12_in_run", ld_add & ld_mult, 1);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1 chk_zero("abort");
      sb_q.delete();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("abort_busy", busy, 0);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_no_valid", result_valid, 0);
      push_pass(2, 9);
      run_start(9);
      chk("restart_w_addr", w_addr, 0);
      chk("restart_d_addr", d_addr, 9);
      wait_done("restart", 301);

      // All-zero weights and bias.
      fill(1, 5);
      push_pass(1, 5);
      run_start(5);
      wait_done("zeros", 301);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
